muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit owning the HI/LO register pair for the MIPS pipeline's execute stage. It replaces single-cycle `*`, `/` and `%` operators with a shift-add multiplier and a restoring divider. Operations are multi-cycle and use a start/busy/done handshake, so the pipeline controller can stall MFHI/MFLO until results are valid. Signed and unsigned multiply and divide, plus MTHI/MTLO, are supported at any operand width.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  request strobe, sampled on the rising edge of CLK.
- Op  in  3  operation select:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7: Start is ignored.
- Rdata1  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- Rdata2  in  WIDTH  multiplier / divisor.
- Busy  out  1  iterative operation in progress; Start is ignored while high.
- Done  out  1  one-cycle pulse when HI/LO have just been updated.
- DivZero  out  1  valid with Done; high when the completed DIV/DIVU had a zero divisor.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
- Reset: state IDLE; HI=0, LO=0, Busy=0, Done=0, DivZero=0; iteration counter 0.
- States: IDLE, ITER, FIX.
- IDLE:
  - Start with Op 0–3 latches operands and goes to ITER.
  - Start with Op 4 writes HI=Rdata1 and stays in IDLE.
  - Start with Op 5 writes LO=Rdata1 and stays in IDLE.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch time.
  - Operand sign bits are stored for FIX.
- ITER runs exactly WIDTH iterations, then goes to FIX.
  - Multiply: one shift-add step per cycle into a 2*WIDTH accumulator.
  - Divide: one restoring subtract step per cycle.
- FIX writes HI/LO, pulses Done, and returns to IDLE.
  - Multiply: {HI,LO} = product, negated (two's complement, 2*WIDTH bits) when signed and signs differ.
  - Divide: LO = quotient, negated when signed and signs differ; HI = remainder, with the sign of the dividend.
- Divide by zero:
  - Result is LO = all ones and HI = dividend (unsigned magnitude path), sign-fixed as above.
  - DivZero=1 with Done.
- Signed most-negative / −1: LO = most-negative value (wrap), HI = 0, DivZero = 0.
- DivZero is 0 on Done for every non-divide operation.
- HI/LO hold their previous values throughout ITER and change only in FIX.
- Start while Busy is dropped; there is no queueing and no error flag.

## Timing
- Iterative op accepted at edge e0:
  - Busy is high from after e0 through after e(WIDTH+1), i.e. WIDTH+1 cycles.
  - HI/LO are written at e(WIDTH+1).
  - Done is high for the one cycle after e(WIDTH+1); Busy is low in that same cycle.
  - For WIDTH=32, the result is visible 33 edges after acceptance.
- Back-to-back operation: Start may be asserted in the Done cycle and is accepted at that edge.
- MTHI/MTLO: written at the accepting edge; Done pulses in the next cycle; Busy stays 0.
- RST mid-operation aborts at the next edge:
  - All outputs take their reset values.
  - No Done is issued for the aborted operation.
- RST has priority over Start.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiplier.
  - HI/LO are written at the accepting edge and Done pulses the next cycle; Busy never asserts for multiplies.
  - DIV/DIVU remain iterative.
- MULDIV_FAST_MUL_EN undefined: all four arithmetic ops take the iterative WIDTH+1-cycle path described above.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002 (WIDTH=32, iterative) -> HI=0x00000001, LO=0xFFFFFFFE; Done exactly 33 edges after acceptance.
- MULT 0xFFFFFFFD (−3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) ÷ 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, DivZero=0.
- DIVU 5 ÷ 0 -> LO=0xFFFFFFFF, HI=0x00000005, DivZero=1 with Done.
- DIV 0x80000000 ÷ 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU during Busy is ignored (HI/LO reflect only the first op); RST asserted at iteration 10 -> HI=LO=0, Busy=0, no Done.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier and restoring divider.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for MULT/MULTU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   mcand;    // multiplicand or divisor magnitude
    logic               is_mul, op_signed, sign_a, sign_b, dzero;

    logic               iter_op, op_sgn_in, neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = Op[0] ? {{WIDTH{1'b0}}, Rdata1} : {{WIDTH{Rdata1[WIDTH-1]}}, Rdata1};
    assign ext_b     = Op[0] ? {{WIDTH{1'b0}}, Rdata2} : {{WIDTH{Rdata2[WIDTH-1]}}, Rdata2};
    assign fast_prod = ext_a * ext_b;
    assign iter_op   = (Op == 3'd2) || (Op == 3'd3);
`else
    assign iter_op   = (Op <= 3'd3);
`endif

    assign op_sgn_in = (Op == 3'd0) || (Op == 3'd2);
    assign mag_a     = (op_sgn_in && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
    assign mag_b     = (op_sgn_in && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;

    // One shift-add step: add multiplicand to the upper half when the low bit is set, then shift right.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // One restoring step; the remainder stays below the divisor so WIDTH bits hold it.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_rem   = div_shift[WIDTH-1:0] - mcand;
    assign div_next  = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign neg       = op_signed && (sign_a ^ sign_b);
    assign prod_fix  = neg ? -acc : acc;
    assign quo_fix   = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = (op_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign Busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (Start && iter_op) state_n = ITER;
            ITER:    if (cnt == CW'(WIDTH - 1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            is_mul    <= 1'b0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dzero     <= 1'b0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (Start) begin
                        if (iter_op) begin
                            is_mul    <= ~Op[1];
                            op_signed <= op_sgn_in;
                            sign_a    <= Rdata1[WIDTH-1];
                            sign_b    <= Rdata2[WIDTH-1];
                            dzero     <= (Rdata2 == '0);
                            acc       <= {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
                            mcand     <= Op[1] ? mag_b : mag_a;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (Op <= 3'd1) begin
                            {HI, LO} <= fast_prod;
                            Done     <= 1'b1;
                        end
`endif
                        else if (Op == 3'd4) begin
                            HI   <= Rdata1;
                            Done <= 1'b1;
                        end else if (Op == 3'd5) begin
                            LO   <= Rdata1;
                            Done <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc <= is_mul ? mul_next : div_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_mul) begin
                        {HI, LO} <= prod_fix;
                    end else begin
                        HI      <= rem_fix;
                        LO      <= quo_fix;
                        DivZero <= dzero;
                    end
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
